// File: rtl/fp_accum.sv
// rtl/fp_accum.sv - streaming FP32 vector accumulator over a latency-hiding ring of partial sums
// Optional element counter port out_cnt is enabled by defining FP_ACCUM_CNT_EN.

// Pipelined FP32 adder, round-to-nearest-even, subnormals flushed to signed zero.
module fp_add #(
  parameter int LAT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_vld,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        sum_vld,
  output logic [31:0] sum
);

  function automatic logic [31:0] fadd(input logic [31:0] ia, input logic [31:0] ib);
    logic [31:0] x, y, res;
    logic [7:0]  ex, ey, d;
    logic [26:0] mx, my, sh;
    logic [27:0] s;
    logic [24:0] r;
    logic        rup, found;
    int          e, lz;
    res = '0;
    // x always carries the larger magnitude so the exponent difference is non-negative
    if (ia[30:0] >= ib[30:0]) begin x = ia; y = ib; end
    else begin x = ib; y = ia; end
    ex = x[30:23];
    ey = y[30:23];
    if (ex == 8'hff) begin
      res = x;
    end else if (ey == 8'd0) begin
      res = (ex == 8'd0) ? {x[31] & y[31], 31'd0} : x;
    end else begin
      mx = {1'b1, x[22:0], 3'b000};
      my = {1'b1, y[22:0], 3'b000};
      d  = ex - ey;
      if (d >= 8'd27) begin
        sh = 27'd1;
      end else begin
        sh    = my >> d;
        sh[0] = sh[0] | (|(my & ((27'd1 << d) - 27'd1)));
      end
      e = {24'd0, ex};
      if (x[31] == y[31]) begin
        s = {1'b0, mx} + {1'b0, sh};
        if (s[27]) begin
          s = {1'b0, s[27:2], s[1] | s[0]};
          e = e + 1;
        end
      end else begin
        s     = {1'b0, mx} - {1'b0, sh};
        lz    = 0;
        found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
          if (!found) begin
            if (s[i]) found = 1'b1;
            else lz++;
          end
        end
        s = s << lz;
        e = e - lz;
      end
      rup = s[2] & (s[1] | s[0] | s[3]);
      r   = {1'b0, s[26:3]} + {24'd0, rup};
      if (r[24]) begin
        r = r >> 1;
        e = e + 1;
      end
      if (s == 28'd0) res = 32'd0;
      else if (e >= 255) res = {x[31], 8'hff, 23'd0};
      else if (e <= 0 || !r[23]) res = {x[31], 31'd0};
      else res = {x[31], e[7:0], r[22:0]};
    end
    return res;
  endfunction

  logic [31:0]    pipe [LAT];
  logic [LAT-1:0] vpipe;

  always_ff @(posedge clk) begin
    pipe[0] <= fadd(a, b);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end

  always_ff @(posedge clk) begin
    if (rst) vpipe <= '0;
    else vpipe <= {vpipe[LAT-2:0], in_vld};
  end

  assign sum     = pipe[LAT-1];
  assign sum_vld = vpipe[LAT-1];

endmodule

module fp_accum #(
  parameter int ADD_LAT = 8
`ifdef FP_ACCUM_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_vld,
  output logic        in_rdy,
  input  logic [31:0] in_data,
  input  logic        in_last,
  output logic        out_vld,
  input  logic        out_rdy,
  output logic [31:0] out_data
`ifdef FP_ACCUM_CNT_EN
  , output logic [CNT_W-1:0] out_cnt
`endif
);

  localparam int LW = $clog2(ADD_LAT + 2);

  typedef enum logic [1:0] {ACCUM, DRAIN, DONE} state_t;

  state_t state_q, state_d;

  // Ring slot tags: rv = slot holds a value, ra = slot is travelling through the adder.
  logic [ADD_LAT-1:0] rv, ra;
  logic [31:0]        byp [ADD_LAT];
  logic [31:0]        pend;
  logic               pend_v;
  logic [LW-1:0]      live;

  logic        sum_vld;
  logic [31:0] sum;
  logic        hv, acc;
  logic [31:0] hval;

  logic        add_vld, slot_v, slot_a, live_inc, live_dec, pend_ld, pend_clr, fin, hs;
  logic [31:0] add_a, add_b, slot_d;

  assign hv     = rv[ADD_LAT-1] && (!ra[ADD_LAT-1] || sum_vld);
  assign hval   = ra[ADD_LAT-1] ? sum : byp[ADD_LAT-1];
  assign in_rdy = (state_q == ACCUM);
  assign acc    = in_vld && in_rdy;

  fp_add #(.LAT(ADD_LAT)) u_add (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (add_vld),
    .a       (add_a),
    .b       (add_b),
    .sum_vld (sum_vld),
    .sum     (sum)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ACCUM;
    else state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    add_vld  = 1'b0;
    add_a    = in_data;
    add_b    = hval;
    slot_v   = 1'b0;
    slot_a   = 1'b0;
    slot_d   = hval;
    live_inc = 1'b0;
    live_dec = 1'b0;
    pend_ld  = 1'b0;
    pend_clr = 1'b0;
    fin      = 1'b0;
    hs       = 1'b0;
    case (state_q)
      ACCUM: begin
        if (acc) begin
          slot_v = 1'b1;
          if (hv) begin
            add_vld = 1'b1;
            slot_a  = 1'b1;
          end else begin
            slot_d   = in_data;
            live_inc = 1'b1;
          end
          if (in_last) state_d = DRAIN;
        end else if (hv) begin
          slot_v = 1'b1;
        end
      end
      DRAIN: begin
        // Pairwise reduction: park one partial in pend, fold it into the next one that arrives.
        if (hv && pend_v) begin
          add_vld  = 1'b1;
          add_a    = pend;
          slot_v   = 1'b1;
          slot_a   = 1'b1;
          pend_clr = 1'b1;
          live_dec = 1'b1;
        end else if (hv) begin
          pend_ld = 1'b1;
        end else if (live == LW'(1) && pend_v && !(|rv)) begin
          fin     = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_rdy) begin
          hs      = 1'b1;
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rv       <= '0;
      ra       <= '0;
      live     <= '0;
      pend_v   <= 1'b0;
      pend     <= '0;
      out_vld  <= 1'b0;
      out_data <= '0;
    end else begin
      rv <= {rv[ADD_LAT-2:0], slot_v};
      ra <= {ra[ADD_LAT-2:0], slot_a};
      if (live_inc) live <= live + LW'(1);
      else if (live_dec) live <= live - LW'(1);
      if (pend_ld) begin
        pend   <= hval;
        pend_v <= 1'b1;
      end else if (pend_clr) begin
        pend_v <= 1'b0;
      end
      if (fin) begin
        out_vld  <= 1'b1;
        out_data <= pend;
      end
      if (hs) begin
        rv      <= '0;
        ra      <= '0;
        live    <= '0;
        pend_v  <= 1'b0;
        out_vld <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    byp[0] <= slot_d;
    for (int i = 1; i < ADD_LAT; i++) byp[i] <= byp[i-1];
  end

`ifdef FP_ACCUM_CNT_EN
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || hs) cnt <= '0;
    else if (acc && !(&cnt)) cnt <= cnt + CNT_W'(1);
  end

  assign out_cnt = cnt;
`endif

endmodule

// File: tb/tb_fp_accum.sv
// tb/tb_fp_accum.sv - randomized self-checking bench for fp_accum against an exact quarter-unit sum model
module tb_fp_accum;

  localparam int LAT = 8;

  logic        clk = 1'b0;
  logic        rst, in_vld, in_last, out_rdy;
  logic [31:0] in_data;
  logic        in_rdy, out_vld;
  logic [31:0] out_data;
`ifdef FP_ACCUM_CNT_EN
  logic [15:0] out_cnt;
`endif

  int          total = 0;
  int          bad = 0;
  bit          rnd_rdy = 1'b0;
  logic [31:0] exp_q[$];
  int          cnt_q[$];

  fp_accum #(.ADD_LAT(LAT)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (in_vld),
    .in_rdy   (in_rdy),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy),
    .out_data (out_data)
`ifdef FP_ACCUM_CNT_EN
    , .out_cnt (out_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Values are multiples of 0.25 with small magnitude, so every partial sum is exact in FP32
  // and the result is independent of the order the ring combines elements in.
  function automatic logic [31:0] q2f(input int q);
    int m, p, ex, mant;
    if (q == 0) return 32'd0;
    m = (q < 0) ? -q : q;
    p = 0;
    for (int i = 0; i < 31; i++) if (m >= (1 << i)) p = i;
    ex   = 127 + p - 2;
    mant = (m << (23 - p)) & 32'h007FFFFF;
    return {q < 0, ex[7:0], mant[22:0]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic last);
    int n = 0;
    in_vld  = 1'b1;
    in_data = d;
    in_last = last;
    while (!in_rdy && n < 300) begin
      step();
      n++;
    end
    if (!in_rdy) chk("send_rdy_timeout", {31'd0, in_rdy}, 32'd1);
    else step();
  endtask

  task automatic idle(input int n);
    in_vld  = 1'b0;
    in_last = 1'b0;
    in_data = $urandom;
    repeat (n) step();
  endtask

  task automatic expect_out(input logic [31:0] d, input int c);
    exp_q.push_back(d);
    cnt_q.push_back(c);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      step();
      n++;
    end
    chk("drain_timeout", exp_q.size(), 32'd0);
  endtask

  task automatic chk_reset_state(input string nm);
    chk({nm, "_in_rdy"}, {31'd0, in_rdy}, 32'd1);
    chk({nm, "_out_vld"}, {31'd0, out_vld}, 32'd0);
    chk({nm, "_out_data"}, out_data, 32'd0);
`ifdef FP_ACCUM_CNT_EN
    chk({nm, "_out_cnt"}, {16'd0, out_cnt}, 32'd0);
`endif
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_rdy) out_rdy = ($urandom_range(3, 0) != 0);
    end
  end

  // Output checker: every accepted result must match the oldest expected sum, and a stalled
  // result must hold its value while the input side stays closed.
  initial begin
    bit          hold = 1'b0;
    logic [31:0] hd = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          chk("hold_vld", {31'd0, out_vld}, 32'd1);
          chk("hold_data", out_data, hd);
        end
        if (out_vld) begin
          chk("in_rdy_in_done", {31'd0, in_rdy}, 32'd0);
          if (out_rdy) begin
            if (exp_q.size() == 0) begin
              chk("unexpected_out", {31'd0, out_vld}, 32'd0);
            end else begin
              chk("sum", out_data, exp_q.pop_front());
`ifdef FP_ACCUM_CNT_EN
              chk("cnt", {16'd0, out_cnt}, cnt_q.pop_front());
`else
              void'(cnt_q.pop_front());
`endif
            end
          end
        end
        hold = out_vld && !out_rdy;
        hd   = out_data;
      end
    end
  end

  initial begin
    int          ks[20];
    int          len, sum, n;
    bit          got;
    int          abort_len[2] = '{5, 12};
    rst     = 1'b1;
    in_vld  = 1'b0;
    in_last = 1'b0;
    in_data = '0;
    out_rdy = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    chk_reset_state("reset");

    chk("model_1p0", q2f(4), 32'h3F800000);
    chk("model_m2p5", q2f(-10), 32'hC0200000);
    chk("model_16p0", q2f(64), 32'h41800000);

    expect_out(32'h40C00000, 3);
    send(32'h3F800000, 1'b0);
    send(32'h40000000, 1'b0);
    send(32'h40400000, 1'b1);
    idle(1);
    wait_drain();

    expect_out(32'h40490FDB, 1);
    send(32'h40490FDB, 1'b1);
    in_vld = 1'b0;
    n = 0;
    got = 1'b0;
    while (n < LAT + 2 && !got) begin
      step();
      n++;
      got = out_vld;
    end
    chk("single_latency", {31'd0, got}, 32'd1);
    wait_drain();

    expect_out(32'h41800000, 16);
    for (int i = 0; i < 16; i++) begin
      chk("b2b_in_rdy", {31'd0, in_rdy}, 32'd1);
      send(32'h3F800000, i == 15);
    end
    idle(1);
    wait_drain();

    expect_out(32'h00000000, 2);
    send(32'h40A00000, 1'b0);
    send(32'hC0A00000, 1'b1);
    idle(1);
    wait_drain();

    out_rdy = 1'b0;
    expect_out(32'h40400000, 1);
    send(32'h40400000, 1'b1);
    in_vld  = 1'b1;
    in_data = 32'h7F7FFFFF;
    in_last = 1'b1;
    n = 0;
    while (!out_vld && n < 100) begin
      step();
      n++;
    end
    chk("stall_out_vld", {31'd0, out_vld}, 32'd1);
    repeat (10) begin
      step();
      chk("stall_in_rdy", {31'd0, in_rdy}, 32'd0);
    end
    out_rdy = 1'b1;
    step();
    chk("in_rdy_after_hs", {31'd0, in_rdy}, 32'd1);
    expect_out(32'h40800000, 2);
    send(32'h40000000, 1'b0);
    send(32'h40000000, 1'b1);
    idle(1);
    wait_drain();

    foreach (abort_len[a]) begin
      for (int i = 0; i < abort_len[a]; i++) send(q2f(int'($urandom_range(40, 1))), 1'b0);
      in_vld = 1'b0;
      rst    = 1'b1;
      step();
      rst = 1'b0;
      chk_reset_state("abort");
      expect_out(32'h40000000, 2);
      send(32'h3F800000, 1'b0);
      send(32'h3F800000, 1'b1);
      idle(1);
      wait_drain();
    end

    rnd_rdy = 1'b1;
    for (int v = 0; v < 40; v++) begin
      len = int'($urandom_range(20, 1));
      sum = 0;
      for (int i = 0; i < len; i++) begin
        ks[i] = int'($urandom_range(800, 0)) - 400;
        sum += ks[i];
      end
      expect_out(q2f(sum), len);
      for (int i = 0; i < len; i++) begin
        send(q2f(ks[i]), i == len - 1);
        if ($urandom_range(2, 0) == 0) idle(int'($urandom_range(3, 1)));
      end
      in_vld = 1'b0;
    end
    idle(1);
    wait_drain();
    rnd_rdy = 1'b0;
    step();
    out_rdy = 1'b1;
    idle(20);
    chk("leftover_expected", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
